// File: rtl/pixel_frame_parser_pkg.sv
// Shared encodings and defaults for the pixel frame parser and the ws2811 drivers.
package pixel_frame_parser_pkg;
  localparam int DEF_UNIVERSES   = 16;
  localparam int DEF_PIXEL_COUNT = 150;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_BLUE   = 3'd2,
    ST_GREEN  = 3'd3,
    ST_RED    = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_CHECK  = 3'd6
  } state_e;

  // Bytes arrive B,G,R on the wire; the RAM word is {R,G,B}.
  function automatic logic [23:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    return {r, g, b};
  endfunction
endpackage

// File: rtl/pixel_frame_parser_cs_sync.sv
// Two-flop synchroniser for the SPI chip select; idles high (deselected) out of reset.
module cs_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_i,
  output logic cs_s_o
);
  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= cs_i;
      sync_q <= meta_q;
    end
  end

  assign cs_s_o = sync_q;
endmodule

// File: rtl/pixel_frame_parser.sv
// SPI byte stream -> per-pixel frame RAM writes plus deferred per-universe start pulses.
// Optional trailing XOR checksum byte gating the start: define PIXEL_PARSER_CHECKSUM_EN.
module pixel_frame_parser
  import pixel_frame_parser_pkg::*;
#(
  parameter int UNIVERSES   = DEF_UNIVERSES,
  parameter int PIXEL_COUNT = DEF_PIXEL_COUNT,
  parameter int UNIV_W      = 4,
  parameter int ADDR_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  input  logic [UNIVERSES-1:0] drv_sending,
  output logic                 wr_en,
  output logic [UNIV_W-1:0]    wr_universe,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [23:0]          wr_rgb,
  output logic [UNIVERSES-1:0] frame_start,
  output logic                 busy,
  output logic                 err_short,
  output logic                 err_universe
);
  logic cs_s;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, wr_addr_q, wr_addr_d;
  logic [UNIV_W-1:0] univ_q, univ_d, wr_univ_q, wr_univ_d;
  logic [7:0] b_q, b_d, g_q, g_d;
  logic [23:0] wr_rgb_q, wr_rgb_d;
  logic wr_en_q, wr_en_d, err_short_q, err_short_d, err_univ_q, err_univ_d;
  logic set_pend;
  logic [UNIVERSES-1:0] pend_q, pend_d, start_q, fire, set_mask;
  logic [1:0] prime_q;
  logic armed_q, armed_d;
  logic last_pix;

  cs_sync u_cs_sync (.clk(clk), .rst_n(rst_n), .cs_i(cs), .cs_s_o(cs_s));

  // cs_s shows its reset value for two cycles; a new frame needs a genuine cs high first.
  assign armed_d  = armed_q | (prime_q[1] & cs_s);
  assign last_pix = (cnt_q == ADDR_W'(PIXEL_COUNT - 1));

`ifdef PIXEL_PARSER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xor_q <= 8'd0;
    else        xor_q <= xor_d;
  end
`endif

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  univ_d = univ_q;  b_d = b_q;  g_d = g_q;
    wr_en_d = 1'b0;  wr_univ_d = wr_univ_q;  wr_addr_d = wr_addr_q;  wr_rgb_d = wr_rgb_q;
    err_short_d = 1'b0;  err_univ_d = 1'b0;  set_pend = 1'b0;
`ifdef PIXEL_PARSER_CHECKSUM_EN
    xor_d = xor_q;
    if (byte_valid && !cs_s && state_q inside {ST_BLUE, ST_GREEN, ST_RED}) xor_d = xor_q ^ byte_data;
`endif
    // A cs release beats a byte arriving on the same cycle.
    if (cs_s && state_q inside {ST_HEADER, ST_BLUE, ST_GREEN, ST_RED, ST_CHECK}) begin
      err_short_d = 1'b1;
      state_d     = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (!cs_s && armed_q) state_d = ST_HEADER;
        ST_HEADER: if (byte_valid) begin
          univ_d = byte_data[UNIV_W-1:0];
`ifdef PIXEL_PARSER_CHECKSUM_EN
          xor_d = byte_data;
`endif
          if ({24'd0, byte_data} >= 32'(UNIVERSES)) begin
            err_univ_d = 1'b1;
            state_d    = ST_DRAIN;
          end else begin
            cnt_d   = '0;
            state_d = ST_BLUE;
          end
        end
        ST_BLUE:  if (byte_valid) begin b_d = byte_data; state_d = ST_GREEN; end
        ST_GREEN: if (byte_valid) begin g_d = byte_data; state_d = ST_RED;   end
        ST_RED: if (byte_valid) begin
          wr_en_d   = 1'b1;
          wr_univ_d = univ_q;
          wr_addr_d = cnt_q;
          wr_rgb_d  = pack_rgb(byte_data, g_q, b_q);
          if (last_pix) begin
`ifdef PIXEL_PARSER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            set_pend = 1'b1;
            state_d  = ST_DRAIN;
`endif
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_BLUE;
          end
        end
`ifdef PIXEL_PARSER_CHECKSUM_EN
        ST_CHECK: if (byte_valid) begin
          if (byte_data == xor_q) set_pend    = 1'b1;
          else                    err_short_d = 1'b1;
          state_d = ST_DRAIN;
        end
`endif
        ST_DRAIN: if (cs_s) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Fire decisions use registered pending only, so a start trails its set by a cycle.
  assign set_mask = set_pend ? (UNIVERSES'(1) << univ_q) : '0;
  assign fire     = pend_q & ~drv_sending;
  assign pend_d   = (pend_q & ~fire) | set_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;  cnt_q <= '0;  univ_q <= '0;  b_q <= 8'd0;  g_q <= 8'd0;
      wr_en_q <= 1'b0;  wr_univ_q <= '0;  wr_addr_q <= '0;  wr_rgb_q <= 24'd0;
      err_short_q <= 1'b0;  err_univ_q <= 1'b0;
      pend_q <= '0;  start_q <= '0;  prime_q <= 2'b00;  armed_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  univ_q <= univ_d;  b_q <= b_d;  g_q <= g_d;
      wr_en_q <= wr_en_d;  wr_univ_q <= wr_univ_d;  wr_addr_q <= wr_addr_d;  wr_rgb_q <= wr_rgb_d;
      err_short_q <= err_short_d;  err_univ_q <= err_univ_d;
      pend_q <= pend_d;  start_q <= fire;  prime_q <= {prime_q[0], 1'b1};  armed_q <= armed_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_universe  = wr_univ_q;
  assign wr_addr      = wr_addr_q;
  assign wr_rgb       = wr_rgb_q;
  assign frame_start  = start_q;
  assign busy         = (state_q != ST_IDLE);
  assign err_short    = err_short_q;
  assign err_universe = err_univ_q;
endmodule
